// File: rtl/bus_demux_reg_pkg.sv
// Shared definitions for the registered bus demultiplexer.
//   DEMUX_WIDTH_DEFAULT : default data word width
//   DEMUX_CH_MAX        : largest supported channel count
//   DROP_CNT_W          : width of the saturating drop counter
//   slot_state_e        : per-slot holding register state
//   demux_free_mask()   : slots able to take a word this cycle
package demux_pkg;

    localparam int unsigned DEMUX_WIDTH_DEFAULT = 8;
    localparam int unsigned DEMUX_CH_MAX        = 16;
    localparam int unsigned DROP_CNT_W          = 8;

    typedef enum logic {
        SlotEmpty = 1'b0,
        SlotFull  = 1'b1
    } slot_state_e;

    // A slot is free when empty or when it drains in the same cycle.
    function automatic logic [DEMUX_CH_MAX-1:0] demux_free_mask(
        input logic [DEMUX_CH_MAX-1:0] valid,
        input logic [DEMUX_CH_MAX-1:0] ready
    );
        return ~valid | (valid & ready);
    endfunction

endpackage

// File: rtl/bus_demux_reg_if.sv
// Bus bundle between a single source and CHANNELS registered destinations.
//   in_valid/in_ready/in_data/in_sel/in_bcast : source handshake
//   out_valid/out_ready/out_data              : per-channel handshake, data flattened
//   err_sel/drop_cnt                          : out-of-range drop reporting
// The slave modport is the demultiplexer's view, master is the environment's.
interface bus_demux_reg_if
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH    = DEMUX_WIDTH_DEFAULT,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = $clog2(CHANNELS)
);

    logic                        in_valid;
    logic                        in_ready;
    logic [WIDTH-1:0]            in_data;
    logic [SEL_W-1:0]            in_sel;
    logic                        in_bcast;
    logic [CHANNELS-1:0]         out_valid;
    logic [CHANNELS-1:0]         out_ready;
    logic [CHANNELS*WIDTH-1:0]   out_data;
    logic                        err_sel;
    logic [DROP_CNT_W-1:0]       drop_cnt;

    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data, err_sel, drop_cnt
    );

    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data, err_sel, drop_cnt
    );

endinterface

// File: rtl/bus_demux_reg_slot.sv
// One-entry holding register for a single demultiplexer channel.
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture load_data and mark full (wins over pop)
//   load_data : word to capture
//   pop       : consumer took the word; empties the slot unless loading
//   valid     : slot full
//   data      : held word, IDLE_VAL while empty
module demux_slot
    import demux_pkg::*;
#(
    parameter int unsigned      WIDTH    = DEMUX_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] IDLE_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    slot_state_e      r_state;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SlotEmpty;
            r_data  <= IDLE_VAL;
        end else if (load) begin
            r_state <= SlotFull;
            r_data  <= load_data;
        end else if (pop) begin
            r_state <= SlotEmpty;
            r_data  <= IDLE_VAL;
        end
    end

    assign valid = (r_state == SlotFull);
    assign data  = r_data;

endmodule

// File: rtl/bus_demux_reg.sv
// Registered 1:N bus demultiplexer with unicast and broadcast delivery.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of bus_demux_reg_if (source handshake, per-channel
//              outputs, err_sel drop pulse, saturating drop_cnt)
// Words addressed past the last channel are accepted and dropped.
module bus_demux_reg
    import demux_pkg::*;
#(
    parameter int unsigned      WIDTH    = DEMUX_WIDTH_DEFAULT,
    parameter int unsigned      CHANNELS = 4,
    parameter int unsigned      SEL_W    = $clog2(CHANNELS),
    parameter logic [WIDTH-1:0] IDLE_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_demux_reg_if.slave       bus
);

    logic [DEMUX_CH_MAX-1:0] w_free_full;
    logic [CHANNELS-1:0]     w_free;
    logic [CHANNELS-1:0]     w_valid;
    logic [CHANNELS-1:0]     w_pop;
    logic [CHANNELS-1:0]     w_load;
    logic [CHANNELS-1:0]     w_sel_hot;
    logic                    w_sel_free;
    logic                    w_in_range;
    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_drop;
    logic                    w_unused_free;
    logic [WIDTH-1:0]        w_slot_data [CHANNELS];

    logic                    r_err_sel;
    logic [DROP_CNT_W-1:0]   r_drop_cnt;

    assign w_free_full   = demux_free_mask(DEMUX_CH_MAX'(w_valid), DEMUX_CH_MAX'(bus.out_ready));
    assign w_free        = w_free_full[CHANNELS-1:0];
    // Upper mask bits are padding when CHANNELS < DEMUX_CH_MAX.
    assign w_unused_free = ^w_free_full;

    assign w_in_range = (32'(bus.in_sel) < CHANNELS);

    // Decode by compare so an out-of-range select never indexes past the vector.
    always_comb begin
        w_sel_free = 1'b0;
        w_sel_hot  = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (bus.in_sel == SEL_W'(i)) begin
                w_sel_free   = w_free[i];
                w_sel_hot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        if (rst) begin
            w_in_ready = 1'b0;
        end else if (bus.in_bcast) begin
            w_in_ready = &w_free;
        end else if (w_in_range) begin
            w_in_ready = w_sel_free;
        end else begin
            w_in_ready = 1'b1;
        end
    end

    assign w_accept = bus.in_valid & w_in_ready;
    assign w_drop   = w_accept & ~bus.in_bcast & ~w_in_range;
    assign w_pop    = w_valid & bus.out_ready;

    always_comb begin
        w_load = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            w_load[i] = w_accept & (bus.in_bcast | w_sel_hot[i]);
        end
    end

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_slot
        demux_slot #(
            .WIDTH    (WIDTH),
            .IDLE_VAL (IDLE_VAL)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (w_load[g]),
            .load_data (bus.in_data),
            .pop       (w_pop[g]),
            .valid     (w_valid[g]),
            .data      (w_slot_data[g])
        );
        assign bus.out_data[g*WIDTH +: WIDTH] = w_slot_data[g];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_sel  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_err_sel <= w_drop;
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_valid;
    assign bus.err_sel   = r_err_sel;
    assign bus.drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_bus_demux_reg.sv
// Directed self-checking bench for bus_demux_reg.
// DUT A: 4 channels, idle value 0x00. DUT B: 3 channels, idle value 0xEE.
module tb_bus_demux_reg;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    bus_demux_reg_if #(.WIDTH(8), .CHANNELS(4)) bus_a ();
    bus_demux_reg_if #(.WIDTH(8), .CHANNELS(3)) bus_b ();

    bus_demux_reg #(
        .WIDTH    (8),
        .CHANNELS (4),
        .IDLE_VAL (8'h00)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    bus_demux_reg #(
        .WIDTH    (8),
        .CHANNELS (3),
        .IDLE_VAL (8'hEE)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_a.in_valid = 1'b1; bus_a.in_data = 8'h55; bus_a.in_sel = 2'd0; bus_a.in_bcast = 1'b0;
        bus_a.out_ready = 4'b1111;
        bus_b.in_valid = 1'b0; bus_b.in_data = 8'h00; bus_b.in_sel = 2'd0; bus_b.in_bcast = 1'b0;
        bus_b.out_ready = 3'b111;
        tick();
        tick();
        checks++;
        if (bus_a.in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b want 0", bus_a.in_ready);
        end
        checks++;
        if (bus_a.out_valid !== 4'b0000) begin
            errors++; $display("FAIL reset_valid: got %b want 0000", bus_a.out_valid);
        end
        checks++;
        if (bus_a.out_data !== 32'h0000_0000) begin
            errors++; $display("FAIL reset_data_a: got %h want 00000000", bus_a.out_data);
        end
        checks++;
        if (bus_b.out_data !== 24'hEEEEEE) begin
            errors++; $display("FAIL reset_data_b: got %h want eeeeee", bus_b.out_data);
        end
        checks++;
        if (bus_a.err_sel !== 1'b0 || bus_a.drop_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_err: got err=%b cnt=%0d want 0/0",
                               bus_a.err_sel, bus_a.drop_cnt);
        end
        rst = 1'b0;
        bus_a.in_valid = 1'b0;
        tick();
        checks++;
        if (bus_a.out_valid !== 4'b0000) begin
            errors++; $display("FAIL reset_word_lost: got %b want 0000", bus_a.out_valid);
        end
    endtask

    task automatic test_unicast();
        bus_a.out_ready = 4'b1111;
        bus_a.in_valid = 1'b1; bus_a.in_sel = 2'd2; bus_a.in_data = 8'hA5;
        #1;
        checks++;
        if (bus_a.in_ready !== 1'b1) begin
            errors++; $display("FAIL uni_ready: got %b want 1", bus_a.in_ready);
        end
        tick();
        bus_a.in_valid = 1'b0;
        checks++;
        if (bus_a.out_valid !== 4'b0100) begin
            errors++; $display("FAIL uni_valid: got %b want 0100", bus_a.out_valid);
        end
        checks++;
        if (bus_a.out_data !== 32'h00A5_0000) begin
            errors++; $display("FAIL uni_data: got %h want 00a50000", bus_a.out_data);
        end
        checks++;
        if (bus_a.err_sel !== 1'b0) begin
            errors++; $display("FAIL uni_err: got %b want 0", bus_a.err_sel);
        end
        tick();
        checks++;
        if (bus_a.out_valid !== 4'b0000 || bus_a.out_data !== 32'h0) begin
            errors++; $display("FAIL uni_drain: got %b/%h want 0000/00000000",
                               bus_a.out_valid, bus_a.out_data);
        end
    endtask

    task automatic test_backpressure();
        bus_a.out_ready = 4'b1101;
        bus_a.in_valid = 1'b1; bus_a.in_sel = 2'd1; bus_a.in_data = 8'h11;
        tick();
        bus_a.in_data = 8'h22;
        #1;
        checks++;
        if (bus_a.in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_stall_ready: got %b want 0", bus_a.in_ready);
        end
        tick();
        checks++;
        if (bus_a.out_valid !== 4'b0010 || bus_a.out_data !== 32'h0000_1100) begin
            errors++; $display("FAIL bp_hold: got %b/%h want 0010/00001100",
                               bus_a.out_valid, bus_a.out_data);
        end
        bus_a.out_ready = 4'b1111;
        #1;
        checks++;
        if (bus_a.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready: got %b want 1", bus_a.in_ready);
        end
        tick();
        bus_a.in_valid = 1'b0;
        checks++;
        if (bus_a.out_valid !== 4'b0010 || bus_a.out_data !== 32'h0000_2200) begin
            errors++; $display("FAIL bp_second: got %b/%h want 0010/00002200",
                               bus_a.out_valid, bus_a.out_data);
        end
        tick();
        checks++;
        if (bus_a.out_valid !== 4'b0000) begin
            errors++; $display("FAIL bp_drain: got %b want 0000", bus_a.out_valid);
        end
    endtask

    task automatic test_broadcast();
        bus_a.out_ready = 4'b0111;
        bus_a.in_valid = 1'b1; bus_a.in_sel = 2'd3; bus_a.in_data = 8'h99;
        tick();
        bus_a.in_bcast = 1'b1; bus_a.in_sel = 2'd0; bus_a.in_data = 8'h3C;
        #1;
        checks++;
        if (bus_a.in_ready !== 1'b0) begin
            errors++; $display("FAIL bc_stall_ready: got %b want 0", bus_a.in_ready);
        end
        tick();
        checks++;
        if (bus_a.out_valid !== 4'b1000 || bus_a.out_data !== 32'h9900_0000) begin
            errors++; $display("FAIL bc_hold: got %b/%h want 1000/99000000",
                               bus_a.out_valid, bus_a.out_data);
        end
        bus_a.out_ready = 4'b1111;
        #1;
        checks++;
        if (bus_a.in_ready !== 1'b1) begin
            errors++; $display("FAIL bc_release_ready: got %b want 1", bus_a.in_ready);
        end
        tick();
        bus_a.in_valid = 1'b0; bus_a.in_bcast = 1'b0;
        bus_a.out_ready = 4'b0000;
        checks++;
        if (bus_a.out_valid !== 4'b1111 || bus_a.out_data !== 32'h3C3C_3C3C) begin
            errors++; $display("FAIL bc_all: got %b/%h want 1111/3c3c3c3c",
                               bus_a.out_valid, bus_a.out_data);
        end
        tick();
        checks++;
        if (bus_a.out_valid !== 4'b1111 || bus_a.out_data !== 32'h3C3C_3C3C) begin
            errors++; $display("FAIL bc_stalled_hold: got %b/%h want 1111/3c3c3c3c",
                               bus_a.out_valid, bus_a.out_data);
        end
        bus_a.out_ready = 4'b1111;
        tick();
        checks++;
        if (bus_a.out_valid !== 4'b0000 || bus_a.out_data !== 32'h0) begin
            errors++; $display("FAIL bc_drain: got %b/%h want 0000/00000000",
                               bus_a.out_valid, bus_a.out_data);
        end
    endtask

    task automatic test_out_of_range();
        bus_b.out_ready = 3'b111;
        bus_b.in_valid = 1'b1; bus_b.in_sel = 2'd1; bus_b.in_data = 8'h5A;
        tick();
        checks++;
        if (bus_b.out_valid !== 3'b010 || bus_b.out_data !== 24'hEE5AEE) begin
            errors++; $display("FAIL oor_unicast: got %b/%h want 010/ee5aee",
                               bus_b.out_valid, bus_b.out_data);
        end
        bus_b.in_sel = 2'd3; bus_b.in_data = 8'h77;
        #1;
        checks++;
        if (bus_b.in_ready !== 1'b1) begin
            errors++; $display("FAIL oor_ready: got %b want 1", bus_b.in_ready);
        end
        tick();
        bus_b.in_valid = 1'b0;
        checks++;
        if (bus_b.err_sel !== 1'b1 || bus_b.drop_cnt !== 8'd1) begin
            errors++; $display("FAIL oor_first: got err=%b cnt=%0d want 1/1",
                               bus_b.err_sel, bus_b.drop_cnt);
        end
        checks++;
        if (bus_b.out_valid !== 3'b000 || bus_b.out_data !== 24'hEEEEEE) begin
            errors++; $display("FAIL oor_no_deliver: got %b/%h want 000/eeeeee",
                               bus_b.out_valid, bus_b.out_data);
        end
        tick();
        checks++;
        if (bus_b.err_sel !== 1'b0 || bus_b.drop_cnt !== 8'd1) begin
            errors++; $display("FAIL oor_pulse_end: got err=%b cnt=%0d want 0/1",
                               bus_b.err_sel, bus_b.drop_cnt);
        end
        bus_b.in_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (k == 100) begin
                checks++;
                if (bus_b.err_sel !== 1'b1 || bus_b.drop_cnt !== 8'd102) begin
                    errors++; $display("FAIL oor_mid: got err=%b cnt=%0d want 1/102",
                                       bus_b.err_sel, bus_b.drop_cnt);
                end
            end
        end
        bus_b.in_valid = 1'b0;
        checks++;
        if (bus_b.drop_cnt !== 8'd255) begin
            errors++; $display("FAIL oor_saturate: got %0d want 255", bus_b.drop_cnt);
        end
        tick();
        checks++;
        if (bus_b.drop_cnt !== 8'd255 || bus_b.err_sel !== 1'b0) begin
            errors++; $display("FAIL oor_sat_hold: got cnt=%0d err=%b want 255/0",
                               bus_b.drop_cnt, bus_b.err_sel);
        end
    endtask

    task automatic test_reset_mid();
        bus_a.out_ready = 4'b0000;
        bus_a.in_valid = 1'b1; bus_a.in_sel = 2'd0; bus_a.in_data = 8'hAA;
        tick();
        bus_a.in_sel = 2'd2; bus_a.in_data = 8'hBB;
        tick();
        checks++;
        if (bus_a.out_valid !== 4'b0101 || bus_a.out_data !== 32'h00BB_00AA) begin
            errors++; $display("FAIL mid_full: got %b/%h want 0101/00bb00aa",
                               bus_a.out_valid, bus_a.out_data);
        end
        rst = 1'b1;
        bus_a.in_sel = 2'd1; bus_a.in_data = 8'hCC; bus_a.out_ready = 4'b1111;
        #1;
        checks++;
        if (bus_a.in_ready !== 1'b0) begin
            errors++; $display("FAIL mid_ready_in_rst: got %b want 0", bus_a.in_ready);
        end
        tick();
        rst = 1'b0;
        bus_a.in_valid = 1'b0;
        checks++;
        if (bus_a.out_valid !== 4'b0000 || bus_a.out_data !== 32'h0) begin
            errors++; $display("FAIL mid_cleared: got %b/%h want 0000/00000000",
                               bus_a.out_valid, bus_a.out_data);
        end
        checks++;
        if (bus_b.drop_cnt !== 8'd0 || bus_b.out_data !== 24'hEEEEEE) begin
            errors++; $display("FAIL mid_b_cleared: got cnt=%0d data=%h want 0/eeeeee",
                               bus_b.drop_cnt, bus_b.out_data);
        end
        tick();
        checks++;
        if (bus_a.out_valid !== 4'b0000) begin
            errors++; $display("FAIL mid_not_delivered: got %b want 0000", bus_a.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  sel;
        logic [7:0]  word;
        logic [31:0] exp_data;
        logic [3:0]  exp_valid;
        bus_a.out_ready = 4'b1111;
        bus_a.in_bcast = 1'b0;
        for (int k = 0; k < 16; k++) begin
            sel  = 2'(k % 4);
            word = 8'h40 + 8'(k);
            bus_a.in_valid = 1'b1; bus_a.in_sel = sel; bus_a.in_data = word;
            #1;
            checks++;
            if (bus_a.in_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, bus_a.in_ready);
            end
            tick();
            exp_valid = 4'b0001 << sel;
            exp_data  = 32'(word) << (8 * int'(sel));
            checks++;
            if (bus_a.out_valid !== exp_valid || bus_a.out_data !== exp_data) begin
                errors++; $display("FAIL b2b_word[%0d]: got %b/%h want %b/%h", k,
                                   bus_a.out_valid, bus_a.out_data, exp_valid, exp_data);
            end
        end
        bus_a.in_valid = 1'b0;
        tick();
        checks++;
        if (bus_a.out_valid !== 4'b0000) begin
            errors++; $display("FAIL b2b_drain: got %b want 0000", bus_a.out_valid);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_unicast();
        test_backpressure();
        test_broadcast();
        test_out_of_range();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
